lc3_seq_ctrl: RTL and testbench

- Multi-cycle control FSM for the LC3 core.
- Sequences the fetch, decode, execute, writeback and memory stages through the cntrl_e state encoding that the fetch interface consumes (state, br_taken).
- Drives per-stage enables and the data-memory access mode.
- Waits on memory completion handshakes, bounded by a timeout.

---
 rtl/lc3_seq_ctrl_if.sv | 30 +++
 rtl/lc3_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lc3_seq_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lc3_seq_ctrl_if.sv
// Control/handshake bundle between the LC3 sequencer (master) and the datapath (slave).
// The datapath supplies ir/psr and memory completions; the sequencer supplies state, enables and pulses.
interface lc3_seq_ctrl_if;
  logic [15:0] ir;
  logic [2:0]  psr;
  logic        complete_instr;
  logic        complete_data;
  logic [3:0]  state;
  logic        br_taken;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        enable_updatePC;
  logic [1:0]  mem_state;
  logic        illegal_op;
  logic        mem_err;

  modport master (
    input  ir, psr, complete_instr, complete_data,
    output state, br_taken, enable_fetch, enable_decode, enable_execute,
           enable_writeback, enable_updatePC, mem_state, illegal_op, mem_err
  );

  modport slave (
    output ir, psr, complete_instr, complete_data,
    input  state, br_taken, enable_fetch, enable_decode, enable_execute,
           enable_writeback, enable_updatePC, mem_state, illegal_op, mem_err
  );
endinterface

// File: rtl/lc3_seq_ctrl.sv
// LC3 multi-cycle sequencer: Moore FSM, outputs decoded from registered state/flags (0-cycle output latency).
// Memory waits stall on complete_instr/complete_data and abort to UPDATE_PC after MEM_TIMEOUT idle cycles.
module lc3_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [3:0]  RESET_STATE = 4'd1   // CNTRL_FETCH; CNTRL_UPDATE_PC (0) is the other legal value
) (
  input  logic               clk,
  input  logic               rst,
  lc3_seq_ctrl_if.master     bus
);

  typedef enum logic [3:0] {
    CNTRL_UPDATE_PC   = 4'd0,
    CNTRL_FETCH       = 4'd1,
    CNTRL_DECODE      = 4'd2,
    CNTRL_EXECUTE     = 4'd3,
    CNTRL_UPDATE_REGF = 4'd4,
    CNTRL_COMPUTE_PC  = 4'd5,
    CNTRL_COMPUTE_MEM = 4'd6,
    CNTRL_READ_MEM    = 4'd7,
    CNTRL_IND_ADDR_RD = 4'd8,
    CNTRL_WRITE_MEM   = 4'd9
  } cntrl_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  cntrl_e     state_q, state_d;
  logic       taken_q, taken_d;
  logic       illegal_q, illegal_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] opcode;
  logic       in_wait;
  logic       comp;
  logic       ir_unused;

  assign opcode    = bus.ir[15:12];
  assign ir_unused = ^bus.ir[8:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= cntrl_e'(RESET_STATE);
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    err_d     = 1'b0;
    cnt_d     = 8'd0;
    in_wait   = 1'b0;
    comp      = (state_q == CNTRL_FETCH) ? bus.complete_instr : bus.complete_data;

    // For wait states, state_d is the exit taken on completion; the stall/timeout below overrides it.
    case (state_q)
      CNTRL_FETCH: begin
        in_wait = 1'b1;
        state_d = CNTRL_DECODE;
      end
      CNTRL_DECODE: state_d = CNTRL_EXECUTE;
      CNTRL_EXECUTE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_LEA:             state_d = CNTRL_UPDATE_REGF;
          OP_BR, OP_JMP:                              state_d = CNTRL_COMPUTE_PC;
          OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: state_d = CNTRL_COMPUTE_MEM;
          default: begin
            state_d   = CNTRL_UPDATE_PC;
            illegal_d = 1'b1;
          end
        endcase
      end
      CNTRL_UPDATE_REGF: state_d = CNTRL_UPDATE_PC;
      CNTRL_COMPUTE_PC: begin
        state_d = CNTRL_UPDATE_PC;
        taken_d = (opcode == OP_BR) ? |(bus.ir[11:9] & bus.psr) : 1'b1;
      end
      CNTRL_COMPUTE_MEM: begin
        case (opcode)
          OP_LD, OP_LDR:  state_d = CNTRL_READ_MEM;
          OP_LDI, OP_STI: state_d = CNTRL_IND_ADDR_RD;
          OP_ST, OP_STR:  state_d = CNTRL_WRITE_MEM;
          default:        state_d = CNTRL_UPDATE_PC;
        endcase
      end
      CNTRL_IND_ADDR_RD: begin
        in_wait = 1'b1;
        state_d = (opcode == OP_LDI) ? CNTRL_READ_MEM : CNTRL_WRITE_MEM;
      end
      CNTRL_READ_MEM: begin
        in_wait = 1'b1;
        state_d = CNTRL_UPDATE_REGF;
      end
      CNTRL_WRITE_MEM: begin
        in_wait = 1'b1;
        state_d = CNTRL_UPDATE_PC;
      end
      CNTRL_UPDATE_PC: state_d = CNTRL_FETCH;
      default:         state_d = CNTRL_FETCH;
    endcase

    // cnt_d defaults to 0, so every entry into a wait state starts a fresh count.
    if (in_wait && !comp) begin
      if (cnt_q == TMO_LAST) begin
        state_d = CNTRL_UPDATE_PC;
        err_d   = 1'b1;
      end else begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
      end
    end
  end

  logic in_upd;
  assign in_upd = (state_q == CNTRL_UPDATE_PC);

  assign bus.state            = state_q;
  assign bus.br_taken         = in_upd & taken_q;
  assign bus.illegal_op       = in_upd & illegal_q;
  assign bus.mem_err          = in_upd & err_q;
  assign bus.enable_fetch     = (state_q == CNTRL_FETCH);
  assign bus.enable_decode    = (state_q == CNTRL_DECODE);
  assign bus.enable_execute   = (state_q == CNTRL_EXECUTE);
  assign bus.enable_writeback = (state_q == CNTRL_UPDATE_REGF);
  assign bus.enable_updatePC  = in_upd;

  always_comb begin
    bus.mem_state = 2'd3;
    case (state_q)
      CNTRL_READ_MEM:    bus.mem_state = 2'd0;
      CNTRL_IND_ADDR_RD: bus.mem_state = 2'd1;
      CNTRL_WRITE_MEM:   bus.mem_state = 2'd2;
      default:           bus.mem_state = 2'd3;
    endcase
  end

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// Bench for lc3_seq_ctrl: per-instruction cycle traces built from the ISA sequencing rules,
// replayed against the DUT with directed cases followed by randomized instructions and delays.
module tb_lc3_seq_ctrl;
  localparam int TMO = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lc3_seq_ctrl_if bus();

  lc3_seq_ctrl #(.MEM_TIMEOUT(TMO), .RESET_STATE(4'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       br;
    logic       err;
    logic       ill;
    logic       ci;
    logic       cd;
  } step_t;

  step_t q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void push(input logic [3:0] st, input bit br = 0, input bit err = 0,
                               input bit ill = 0, input bit ci = 0, input bit cd = 0);
    step_t s;
    s.st = st; s.br = br; s.err = err; s.ill = ill; s.ci = ci; s.cd = cd;
    q.push_back(s);
  endfunction

  // Wait state st with the completion pulse on wait cycle d (0-based); d >= TMO means it never comes.
  function automatic bit wait_in(input logic [3:0] st, input int d);
    bit instr = (st == 4'd1);
    for (int k = 0; k < TMO; k++) begin
      if (k == d) begin
        push(st, 0, 0, 0, instr, !instr);
        return 1'b1;
      end
      push(st);
    end
    push(4'd0, 0, 1, 0);
    return 1'b0;
  endfunction

  // Expected cycle trace of one instruction, FETCH through UPDATE_PC.
  function automatic void build(input logic [15:0] ir, input logic [2:0] psr,
                                input int d0, input int d1, input int d2);
    logic [3:0] op = ir[15:12];
    logic [2:0] nzp = ir[11:9];
    if (!wait_in(4'd1, d0)) return;
    push(4'd2);
    push(4'd3);
    case (op)
      4'd1, 4'd5, 4'd9, 4'd14: begin push(4'd4); push(4'd0); end
      4'd0:  begin push(4'd5); push(4'd0, (nzp & psr) != 3'd0); end
      4'd12: begin push(4'd5); push(4'd0, 1); end
      4'd2, 4'd6: begin
        push(4'd6);
        if (wait_in(4'd7, d2)) begin push(4'd4); push(4'd0); end
      end
      4'd10: begin
        push(4'd6);
        if (wait_in(4'd8, d1))
          if (wait_in(4'd7, d2)) begin push(4'd4); push(4'd0); end
      end
      4'd11: begin
        push(4'd6);
        if (wait_in(4'd8, d1))
          if (wait_in(4'd9, d2)) push(4'd0);
      end
      4'd3, 4'd7: begin
        push(4'd6);
        if (wait_in(4'd9, d2)) push(4'd0);
      end
      default: push(4'd0, 0, 0, 1);
    endcase
  endfunction

  function automatic logic [1:0] exp_mem_state(input logic [3:0] st);
    case (st)
      4'd7:    return 2'd0;
      4'd8:    return 2'd1;
      4'd9:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic check_step(input step_t s);
    logic [4:0] en_exp;
    en_exp = {s.st == 4'd1, s.st == 4'd2, s.st == 4'd3, s.st == 4'd4, s.st == 4'd0};
    check("state", 16'(bus.state), 16'(s.st));
    check("mem_state", 16'(bus.mem_state), 16'(exp_mem_state(s.st)));
    check("enables", 16'({bus.enable_fetch, bus.enable_decode, bus.enable_execute,
                          bus.enable_writeback, bus.enable_updatePC}), 16'(en_exp));
    check("pulses{br,ill,err}", 16'({bus.br_taken, bus.illegal_op, bus.mem_err}),
          16'({s.br, s.ill, s.err}));
  endtask

  // Entered at posedge+1 with the DUT at the start of a FETCH cycle.
  task automatic run(input logic [15:0] ir, input logic [2:0] psr, input int ncyc);
    step_t s;
    bus.ir  = ir;
    bus.psr = psr;
    for (int i = 0; i < ncyc && q.size() > 0; i++) begin
      s = q.pop_front();
      bus.complete_instr = (s.st == 4'd1) ? s.ci : 1'($urandom_range(0, 1));
      bus.complete_data  = (s.st inside {4'd7, 4'd8, 4'd9}) ? s.cd : 1'($urandom_range(0, 1));
      check_step(s);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic txn(input logic [15:0] ir, input logic [2:0] psr,
                     input int d0, input int d1, input int d2);
    q.delete();
    build(ir, psr, d0, d1, d2);
    run(ir, psr, 1000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 16'(bus.state), 16'd1);
    check({tag, "_mem_state"}, 16'(bus.mem_state), 16'd3);
    check({tag, "_enables"}, 16'({bus.enable_fetch, bus.enable_decode, bus.enable_execute,
                                  bus.enable_writeback, bus.enable_updatePC}), 16'b10000);
    check({tag, "_pulses"}, 16'({bus.br_taken, bus.illegal_op, bus.mem_err}), 16'd0);
  endtask

  initial begin
    bus.ir = 16'h0000;
    bus.psr = 3'b000;
    bus.complete_instr = 1'b1;
    bus.complete_data = 1'b0;
    rst = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    txn(16'h1042, 3'b000, 0, 0, 0);          // ADD
    txn(16'h0A05, 3'b001, 0, 0, 0);          // BRnp, P set -> taken
    txn(16'h0A05, 3'b010, 0, 0, 0);          // BRnp, Z set -> not taken
    txn(16'h0005, 3'b111, 0, 0, 0);          // nzp=000 never taken
    txn(16'hC1C0, 3'b000, 1, 0, 0);          // JMP
    txn(16'hA203, 3'b000, 0, 3, 3);          // LDI, delayed completions
    txn(16'hB203, 3'b000, 2, 1, 3);          // STI
    txn(16'h3001, 3'b000, 0, 0, 0);          // ST
    txn(16'h2001, 3'b000, 0, 0, TMO + 2);    // LD timeout
    txn(16'h2001, 3'b000, 0, 0, TMO - 1);    // completion on the timeout cycle wins
    txn(16'h1042, 3'b000, TMO + 1, 0, 0);    // fetch timeout
    txn(16'hA203, 3'b000, 0, TMO, 0);        // indirect-address timeout
    txn(16'hF025, 3'b000, 0, 0, 0);          // TRAP -> illegal

    // Asynchronous reset in the middle of a READ_MEM wait.
    q.delete();
    build(16'h2001, 3'b000, 0, 0, TMO + 2);
    run(16'h2001, 3'b000, 4);
    check("pre_reset_state", 16'(bus.state), 16'd7);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    rst = 1'b1;
    q.delete();

    for (int n = 0; n < 80; n++) begin
      txn(16'($urandom), 3'($urandom), $urandom_range(0, TMO + 1),
          $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
